rom_loader: RTL and testbench

Byte-stream programmer for the instruction ROM. Consumes framed bytes from an upstream serial receiver, assembles them into little-endian 32-bit words and drives the ROM write port (port 2) starting at word address 0. It verifies length and an XOR checksum, and flags inter-byte timeouts. It reports done/error to the boot controller, which holds the core while `busy` is high.

---
 rtl/rom_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_rom_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: receives framed bytes from the serial receiver and programs the
// instruction ROM through write port 2, starting at word address 0.
// Frame: MAGIC, LEN lo, LEN hi, 4*LEN data bytes (LSB first per word), CSUM.
// It checks the length against the ROM depth, checks the XOR checksum and
// aborts the frame on an inter-byte timeout.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | hunting for MAGIC; every other byte is accepted and dropped
// LEN0  | waiting for the low length byte
// LEN1  | waiting for the high length byte; range check
// DATA  | assembling words, writing the ROM, accumulating the XOR
// CSUM  | waiting for the checksum byte; pulses done or error
module rom_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5,
  parameter int unsigned TIMEOUT    = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en2,
  output logic [ADDR_WIDTH-1:0] addr2,
  output logic [31:0]           wr_data2,
  output logic [3:0]            wr_strobe2,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           wbuf_q, wbuf_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [3:0]            strobe_q, strobe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            code_q, code_d;

  logic                  accept;
  logic                  timeout;
  logic [15:0]           len_new;
  logic [ADDR_WIDTH:0]   widx_inc;

  // The write path never stalls, so the loader is always ready out of reset.
  assign rx_ready = rst_n;
  assign accept   = rx_valid & rx_ready;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    widx_d   = widx_q;
    bcnt_d   = bcnt_q;
    wbuf_d   = wbuf_q;
    csum_d   = csum_q;
    tmr_d    = tmr_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    strobe_d = 4'h0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    code_d   = code_q;
    timeout  = 1'b0;
    len_new  = {rx_data, len_q[7:0]};
    widx_inc = widx_q + 1'b1;

    // Inter-byte timer: down-counter reloaded by every accepted byte; an
    // accepted byte in the terminal cycle wins over the timeout.
    if (state_q != IDLE) begin
      if (accept) begin
        tmr_d = TMR_LOAD;
      end else if (tmr_q == '0) begin
        timeout = 1'b1;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept && (rx_data == MAGIC)) begin
          state_d = LEN0;
          widx_d  = '0;
          bcnt_d  = '0;
          csum_d  = '0;
          tmr_d   = TMR_LOAD;
        end
      end
      LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if (32'(len_new) > DEPTH) begin
            error_d = 1'b1;
            code_d  = ERR_LEN;
            state_d = IDLE;
          end else if (len_new == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          bcnt_d = bcnt_q + 1'b1;
          wbuf_d = {rx_data, wbuf_q[23:8]};
          if (bcnt_q == 2'd3) begin
            wr_en_d  = 1'b1;
            strobe_d = 4'hF;
            addr_d   = widx_q[ADDR_WIDTH-1:0];
            data_d   = {rx_data, wbuf_q};
            widx_d   = widx_inc;
            if (32'(widx_inc) == 32'(len_q)) begin
              state_d = CSUM;
            end
          end
        end
      end
      CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
            code_d  = ERR_CSUM;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      error_d = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      widx_q   <= '0;
      bcnt_q   <= '0;
      wbuf_q   <= '0;
      csum_q   <= '0;
      tmr_q    <= '0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      widx_q   <= widx_d;
      bcnt_q   <= bcnt_d;
      wbuf_q   <= wbuf_d;
      csum_q   <= csum_d;
      tmr_q    <= tmr_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

  assign wr_en2     = wr_en_q;
  assign addr2      = addr_q;
  assign wr_data2   = data_q;
  assign wr_strobe2 = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = code_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: frame-level stimulus with a scoreboard of expected ROM
// writes and done/error pulses, each tagged with the cycle it must appear in.
module tb_rom_loader;

  localparam int         AW    = 4;
  localparam int         TO    = 8;
  localparam int         DEPTH = 16;
  localparam logic [7:0] MAGIC = 8'hA5;

  localparam logic [2:0] K_WR   = 3'b100;
  localparam logic [2:0] K_DONE = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          wr_en2;
  logic [AW-1:0] addr2;
  logic [31:0]   wr_data2;
  logic [3:0]    wr_strobe2;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  rom_loader #(.ADDR_WIDTH(AW), .MAGIC(MAGIC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .wr_en2(wr_en2), .addr2(addr2), .wr_data2(wr_data2),
    .wr_strobe2(wr_strobe2), .busy(busy), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;
    int          addr;
    logic [31:0] data;
    int          code;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] words[DEPTH];
  int          last_code = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input int addr, input logic [31:0] data,
                         input int code, input int c);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.code = code; e.cyc = c;
    exp_q.push_back(e);
  endtask

  function automatic int gap(input int m);
    if (m == 0) return 0;
    return ($urandom % 3 == 0) ? int'($urandom_range(m, 1)) : 0;
  endfunction

  // Presents one byte after g idle cycles; c is the cycle it was accepted in.
  task automatic send_byte(input logic [7:0] b, input int g, output int c);
    repeat (g) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    c        = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends a whole frame built from words[]; predicts writes and outcome.
  task automatic send_frame(input int len, input bit bad, input int maxgap);
    int         c;
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(MAGIC, gap(maxgap), c);
    chk("busy_rise", busy, 1);
    send_byte(len[7:0], gap(maxgap), c);
    send_byte(len[15:8], gap(maxgap), c);
    if (len > DEPTH) begin
      push_ev(K_ERR, 0, 0, 2, c + 1);
      last_code = 2;
      chk("busy_after_len_err", busy, 0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < 4; j++) begin
        b  = words[i][8*j +: 8];
        cs = cs ^ b;
        send_byte(b, gap(maxgap), c);
        if (j == 3) push_ev(K_WR, i, words[i], 0, c + 1);
      end
    end
    if (bad) cs = cs ^ 8'($urandom_range(255, 1));
    send_byte(cs, gap(maxgap), c);
    if (bad) begin
      push_ev(K_ERR, 0, 0, 1, c + 1);
      last_code = 1;
    end else begin
      push_ev(K_DONE, 0, 0, 0, c + 1);
    end
    chk("busy_fall", busy, 0);
  endtask

  // Monitor: every write/done/error the DUT shows must match the next entry.
  always @(negedge clk) begin
    ev_t e;
    if (wr_en2 || done || error) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {wr_en2, done, error}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {wr_en2, done, error}, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (e.kind == K_WR) begin
          chk("wr_addr", addr2, e.addr);
          chk("wr_data", wr_data2, e.data);
          chk("wr_strobe", wr_strobe2, 4'hF);
        end
        if (e.kind == K_ERR) chk("err_code", err_code, e.code);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int len;
    bit bad;

    // Reset and idle behaviour.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_outputs", {wr_en2, addr2, wr_data2, wr_strobe2, busy, done, error, err_code}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_outputs", {wr_en2, addr2, wr_data2, wr_strobe2, busy, done, error, err_code}, 0);
      chk("idle_rx_ready", rx_ready, 1);
    end

    // Two-word frame back-to-back, good checksum (XOR of payload is 0x2A).
    words[0] = 32'h12345678;
    words[1] = 32'hDEADBEEF;
    send_frame(2, 1'b0, 0);
    idle(3);
    // Same payload with a corrupted checksum: writes still happen, then error 1.
    send_frame(2, 1'b1, 0);
    idle(3);

    // Junk before MAGIC, then an over-long frame (LEN=17 > 16 words).
    send_byte(8'h00, 2, c);
    send_byte(8'hFF, 3, c);
    send_frame(17, 1'b0, 2);
    idle(4);
    chk("err_code_hold", err_code, last_code);

    // Timeout: stall after the first data byte.
    send_byte(MAGIC, 0, c);
    send_byte(8'h01, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'hAA, 0, c);
    push_ev(K_ERR, 0, 0, 3, c + TO + 1);
    last_code = 3;
    idle(TO + 4);
    chk("busy_after_timeout", busy, 0);

    // A byte on the last allowed idle cycle keeps the frame alive.
    send_byte(MAGIC, 0, c);
    send_byte(8'h01, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'hAA, 0, c);
    send_byte(8'hBB, TO - 1, c);
    send_byte(8'hCC, 0, c);
    send_byte(8'hDD, 0, c);
    push_ev(K_WR, 0, 32'hDDCCBBAA, 0, c + 1);
    send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 0, c);
    push_ev(K_DONE, 0, 0, 0, c + 1);
    idle(3);

    // Reset after three data bytes: no write, back to idle, reload works.
    send_byte(MAGIC, 0, c);
    send_byte(8'h01, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'h11, 0, c);
    send_byte(8'h22, 0, c);
    send_byte(8'h33, 0, c);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr_en", wr_en2, 0);
    chk("rst_mid_err_code", err_code, 0);
    last_code = 0;
    idle(2);
    words[0] = $urandom;
    send_frame(1, 1'b0, 0);
    idle(3);

    // Randomised frames, including empty, full-depth and over-long lengths.
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
        send_byte(8'($urandom_range(255, 166)) ^ 8'h00, gap(2), c);
      end
      case ($urandom % 8)
        0:       len = 17 + int'($urandom_range(40, 0));
        1:       len = DEPTH;
        2:       len = 0;
        default: len = int'($urandom_range(DEPTH, 1));
      endcase
      bad = ($urandom % 4 == 0);
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      send_frame(len, bad, 3);
      idle(int'($urandom_range(3, 1)));
    end
    chk("err_code_final_hold", err_code, last_code);

    idle(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
